pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage MIPS core; successor to the fixed-width decode/execute latch.
- Carries a generic control/data payload plus the fields every stage shares: PC, branch-delay flag, exception code, write address and hazard timing (T_use/T_new).
- Adds over the previous generation: stall/hold, an explicit valid bit, saturating timing arithmetic, and a bubble counter.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB with different DATA_W.

Parameters:
- DATA_W, 96, width of opaque stage payload (control bits, operands, immediate, instr)
- PC_W, 32, PC width
- EXC_W, 5, exception code width
- T_W, 3, width of T_use/T_new fields
- TUSE_IDLE, 4, T_use value loaded for bubbles (means "no use")
- HANDLER_PC, 32'h0000_4180, PC loaded on exception request
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  1  exception/interrupt entry; squash stage, PC := HANDLER_PC
- flush  in  1  insert bubble; PC and BD still captured from input
- stall  in  1  hold all state
- in_valid  in  1  upstream slot holds a real instruction
- in_pc  in  PC_W  upstream PC
- in_bd  in  1  upstream instruction sits in a delay slot
- in_exc  in  EXC_W  upstream exception code, 0 = none
- in_wa  in  5  destination register, 0 = none
- in_tuse_rs  in  T_W  cycles until rs is needed
- in_tuse_rt  in  T_W  cycles until rt is needed
- in_tnew  in  T_W  cycles until result is produced
- in_payload  in  DATA_W  opaque payload
- out_valid  out  1  stage holds a real instruction
- out_pc  out  PC_W
- out_bd  out  1
- out_exc  out  EXC_W
- out_wa  out  5
- out_tuse_rs  out  T_W
- out_tuse_rt  out  T_W
- out_tnew  out  T_W
- out_payload  out  DATA_W
- bubble_cnt  out  CNT_W  number of bubbles captured since reset

Behaviour:
- All outputs are registered. Latency is 1 cycle from input to output. No combinational in-to-out path.
- Update priority, evaluated each rising clk, highest first:
  - reset: all outputs 0 except out_tuse_rs = out_tuse_rt = TUSE_IDLE; bubble_cnt = 0.
  - req: BUBBLE (defined below) with out_pc = HANDLER_PC, out_bd = 0, out_exc = 0. bubble_cnt unchanged.
  - flush: BUBBLE with out_pc = in_pc, out_bd = in_bd, out_exc = 0. bubble_cnt +1.
  - stall: every register holds its value, including bubble_cnt.
  - in_valid = 0: BUBBLE with out_pc = in_pc, out_bd = in_bd. bubble_cnt +1.
  - in_exc != 0: EXCSLOT. out_valid = 1, out_exc = in_exc, out_pc = in_pc, out_bd = in_bd. Payload, wa and timing take their BUBBLE values, so the faulting instruction has no side effects downstream.
  - otherwise, LOAD. out_valid = 1. pc, bd, exc, wa and payload are copied. Each timing field is stored as sat_dec(in), where sat_dec(x) = (x == 0) ? 0 : x - 1.
- BUBBLE: out_valid = 0, out_payload = 0, out_wa = 0, out_tnew = 0, out_tuse_rs = out_tuse_rt = TUSE_IDLE, out_exc = 0.
- The previous latch decremented T_use without saturation. Here the decrement saturates, so a T_use of 0 never wraps to 7.
- flush while stall is asserted: flush wins (bubble inserted). req while stall is asserted: req wins.
- bubble_cnt saturates at all-ones and never wraps.
- Reset asserted mid-stall: reset wins on that edge. On the first edge after reset deasserts, normal priority applies.

Decomposition:
- Shared package pipe_pkg holds: T_W, TUSE_IDLE, HANDLER_PC, EXC_W, and the sat_dec function (also used by the hazard unit).
- One small sub-module is natural: sat_counter (CNT_W, inc, hold, reset) for bubble_cnt.
- The register body stays flat: one always block implementing the priority chain.

Test Plan:
- Reset then LOAD: in_valid=1, pc=0x3000, wa=5, tnew=2, tuse_rs=1, tuse_rt=0, payload=0xABC -> next cycle out_valid=1, out_pc=0x3000, out_wa=5, out_tnew=1, out_tuse_rs=0, out_tuse_rt=0 (saturated), out_payload=0xABC.
- Stall hold: after the load above, stall=1 for 3 cycles with changing inputs -> outputs frozen at those values and bubble_cnt unchanged; stall=0 -> next input is captured.
- Flush plus stall on the same edge, in_pc=0x3008, in_bd=1 -> out_valid=0, out_pc=0x3008, out_bd=1, out_tuse_rs=4, out_wa=0, bubble_cnt +1.
- Exception slot: in_exc=10, in_pc=0x300C, in_wa=7 -> out_valid=1, out_exc=10, out_wa=0, out_tnew=0, out_payload=0.
- req together with flush and stall -> out_pc=0x0000_4180, out_bd=0, out_exc=0, out_valid=0, bubble_cnt unchanged.
- Counter saturation (CNT_W=4): 20 consecutive in_valid=0 cycles -> bubble_cnt=15. Then assert reset -> bubble_cnt=0 and all other outputs at reset values.

Source files
------------

// File: rtl/pipe_pkg.sv
// Definitions shared by every pipeline stage register and the hazard unit:
// timing-field width, idle T_use, exception handler entry, saturating decrement.
package pipe_pkg;

    localparam int T_W   = 3;
    localparam int EXC_W = 5;
    localparam int WA_W  = 5;

    localparam logic [T_W-1:0] TUSE_IDLE  = 3'd4;
    localparam logic [31:0]    HANDLER_PC = 32'h0000_4180;

    localparam logic [T_W-1:0] T_ONE = 3'd1;

    // Timing fields count down one per stage but must stop at zero instead of wrapping.
    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
        return (x == '0) ? '0 : x - T_ONE;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle of the signals that cross a stage boundary: control, upstream slot and registered stage outputs.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 96,
    parameter int PC_W   = 32,
    parameter int EXC_W  = pipe_pkg::EXC_W,
    parameter int T_W    = pipe_pkg::T_W
);

    logic              req;
    logic              flush;
    logic              stall;

    logic              in_valid;
    logic [PC_W-1:0]   in_pc;
    logic              in_bd;
    logic [EXC_W-1:0]  in_exc;
    logic [4:0]        in_wa;
    logic [T_W-1:0]    in_tuse_rs;
    logic [T_W-1:0]    in_tuse_rt;
    logic [T_W-1:0]    in_tnew;
    logic [DATA_W-1:0] in_payload;

    logic              out_valid;
    logic [PC_W-1:0]   out_pc;
    logic              out_bd;
    logic [EXC_W-1:0]  out_exc;
    logic [4:0]        out_wa;
    logic [T_W-1:0]    out_tuse_rs;
    logic [T_W-1:0]    out_tuse_rt;
    logic [T_W-1:0]    out_tnew;
    logic [DATA_W-1:0] out_payload;

    modport master (
        output req, flush, stall,
        output in_valid, in_pc, in_bd, in_exc, in_wa,
        output in_tuse_rs, in_tuse_rt, in_tnew, in_payload,
        input  out_valid, out_pc, out_bd, out_exc, out_wa,
        input  out_tuse_rs, out_tuse_rt, out_tnew, out_payload
    );

    modport slave (
        input  req, flush, stall,
        input  in_valid, in_pc, in_bd, in_exc, in_wa,
        input  in_tuse_rs, in_tuse_rt, in_tnew, in_payload,
        output out_valid, out_pc, out_bd, out_exc, out_wa,
        output out_tuse_rs, out_tuse_rt, out_tnew, out_payload
    );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Up-counter that sticks at all-ones; used to count bubbles entering a stage.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             hold,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !hold && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: PC, delay-slot flag, exception code, write address,
// hazard timing and an opaque payload, with req/flush/stall priority and a bubble counter.
module pipe_stage_reg #(
    parameter int                    DATA_W     = 96,
    parameter int                    PC_W       = 32,
    parameter int                    EXC_W      = pipe_pkg::EXC_W,
    parameter int                    T_W        = pipe_pkg::T_W,
    parameter logic [T_W-1:0]        TUSE_IDLE  = pipe_pkg::TUSE_IDLE,
    parameter logic [PC_W-1:0]       HANDLER_PC = pipe_pkg::HANDLER_PC,
    parameter int                    CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] bubble_cnt
);

    import pipe_pkg::*;

    logic cnt_inc;
    logic cnt_hold;

    // Bubbles come from a flush or from an empty upstream slot; an exception entry squashes without counting.
    assign cnt_inc  = !bus.req && (bus.flush || (!bus.stall && !bus.in_valid));
    assign cnt_hold = bus.stall && !bus.flush && !bus.req;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc),
        .hold  (cnt_hold),
        .count (bubble_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid   <= 1'b0;
            bus.out_pc      <= '0;
            bus.out_bd      <= 1'b0;
            bus.out_exc     <= '0;
            bus.out_wa      <= '0;
            bus.out_tuse_rs <= TUSE_IDLE;
            bus.out_tuse_rt <= TUSE_IDLE;
            bus.out_tnew    <= '0;
            bus.out_payload <= '0;
        end else if (bus.req) begin
            bus.out_valid   <= 1'b0;
            bus.out_pc      <= HANDLER_PC;
            bus.out_bd      <= 1'b0;
            bus.out_exc     <= '0;
            bus.out_wa      <= '0;
            bus.out_tuse_rs <= TUSE_IDLE;
            bus.out_tuse_rt <= TUSE_IDLE;
            bus.out_tnew    <= '0;
            bus.out_payload <= '0;
        end else if (bus.flush || (!bus.stall && !bus.in_valid)) begin
            bus.out_valid   <= 1'b0;
            bus.out_pc      <= bus.in_pc;
            bus.out_bd      <= bus.in_bd;
            bus.out_exc     <= '0;
            bus.out_wa      <= '0;
            bus.out_tuse_rs <= TUSE_IDLE;
            bus.out_tuse_rt <= TUSE_IDLE;
            bus.out_tnew    <= '0;
            bus.out_payload <= '0;
        end else if (!bus.stall) begin
            bus.out_valid <= 1'b1;
            bus.out_pc    <= bus.in_pc;
            bus.out_bd    <= bus.in_bd;
            bus.out_exc   <= bus.in_exc;
            // A faulting instruction keeps its PC and code but must not write or create hazards downstream.
            if (bus.in_exc != '0) begin
                bus.out_wa      <= '0;
                bus.out_tuse_rs <= TUSE_IDLE;
                bus.out_tuse_rt <= TUSE_IDLE;
                bus.out_tnew    <= '0;
                bus.out_payload <= '0;
            end else begin
                bus.out_wa      <= bus.in_wa;
                bus.out_tuse_rs <= sat_dec(bus.in_tuse_rs);
                bus.out_tuse_rt <= sat_dec(bus.in_tuse_rt);
                bus.out_tnew    <= sat_dec(bus.in_tnew);
                bus.out_payload <= bus.in_payload;
            end
        end
    end

endmodule
